maj_fold_ctrl: RTL and testbench

MAJ_FOLD_CTRL -- requirements
Module: maj_fold_ctrl

---
 rtl/maj_fold_pkg.sv | 16 +
 rtl/maj_fold_ctrl_if.sv | 24 ++
 rtl/maj_chunk_popcnt.sv | 22 ++
 rtl/maj_fold_ctrl.sv | 106 ++++++++++
 tb/tb_maj_fold_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maj_fold_pkg.sv
// Shared constants and FSM state type for the chunked majority-vote controller.
package maj_fold_pkg;

  localparam int N      = 63;
  localparam int CHUNK  = 9;
  localparam int NCHUNK = N / CHUNK;
  localparam int CW     = 6;
  localparam int THRESH = (N + 1) / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

endpackage

// File: rtl/maj_fold_ctrl_if.sv
// Valid/ready vote-vector input and result output bundle for maj_fold_ctrl.
interface maj_fold_ctrl_if #(
  parameter int N = maj_fold_pkg::N
);

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                x;
  logic                        out_valid;
  logic                        out_ready;
  logic                        y;
  logic [maj_fold_pkg::CW-1:0] count;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, count
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, count
  );

endinterface

// File: rtl/maj_chunk_popcnt.sv
// Combinational ones count of one CHUNK-bit slice of the vote vector.
module maj_chunk_popcnt #(
  parameter int CHUNK = 9
) (
  input  logic [CHUNK-1:0] i_bits,
  output logic [3:0]       o_cnt
);

  logic [3:0] w_term [CHUNK];

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_term
    assign w_term[gi] = {3'b000, i_bits[gi]};
  end

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_cnt = o_cnt + w_term[i];
    end
  end

endmodule

// File: rtl/maj_fold_ctrl.sv
// Majority vote over an N-bit vector, folded into N/CHUNK popcount steps
// through a single chunk counter; result handed out over valid/ready.
module maj_fold_ctrl #(
  parameter int N      = maj_fold_pkg::N,
  parameter int CHUNK  = maj_fold_pkg::CHUNK,
  parameter int THRESH = maj_fold_pkg::THRESH
) (
  input  logic           clk,
  input  logic           rst,
  maj_fold_ctrl_if.slave bus
);

  import maj_fold_pkg::*;

  localparam int NCH = N / CHUNK;
  localparam int IW  = $clog2(NCH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  state_t        r_state;
  logic [N-1:0]  r_shift;
  logic [CW-1:0] r_acc;
  logic [IW-1:0] r_idx;
  logic          r_out_valid;
  logic          r_y;
  logic [CW-1:0] r_count;

  logic [3:0]    w_chunk_cnt;
  logic          w_in_ready;
  logic          w_accept;

  maj_chunk_popcnt #(
    .CHUNK (CHUNK)
  ) u_chunk_popcnt (
    .i_bits (r_shift[CHUNK-1:0]),
    .o_cnt  (w_chunk_cnt)
  );

  // DONE can take a new vector only on the edge that also retires the result.
  assign w_in_ready = !rst && ((r_state == S_IDLE) ||
                               ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= bus.x;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          // Index 0..NCH-1 fold one chunk each; the index==NCH cycle publishes
          // the finished accumulator so count/y come straight from a register.
          if (r_idx == LAST_IDX) begin
            r_count     <= r_acc;
            r_y         <= (r_acc >= THRESH_C);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_acc   <= r_acc + CW'(w_chunk_cnt);
            r_shift <= r_shift >> CHUNK;
            r_idx   <= r_idx + IW'(1);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_shift <= bus.x;
              r_acc   <= '0;
              r_idx   <= '0;
              r_state <= S_ACCUM;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// Self-checking bench for maj_fold_ctrl: directed corner cases plus a random
// valid/ready regression scored against a popcount/threshold model.
module tb_maj_fold_ctrl;

  localparam int N        = 63;
  localparam int THR      = 32;
  localparam int LATENCY  = 8;
  localparam int NUM_RAND = 2000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  maj_fold_ctrl_if #(.N(N)) bus ();

  maj_fold_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_count(input logic [N-1:0] v);
    return $countones(v);
  endfunction

  function automatic logic ref_y(input logic [N-1:0] v);
    return ($countones(v) >= THR);
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[N-1:0];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Accepts v with out_ready=1, measures edges until out_valid, captures
  // the result, then lets it be consumed.
  task automatic run_vector(input logic [N-1:0] v, output int lat, output bit ok,
                            output logic [5:0] c, output logic yv);
    bus.out_ready = 1'b1;
    bus.x         = v;
    bus.in_valid  = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    bus.x        = ~v;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      lat++;
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    c  = bus.count;
    yv = bus.y;
    $display("txn x=%h count=%0d y=%0b latency=%0d", v, c, yv, lat);
    cycle();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++;
    if (bus.y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b expected 0", bus.y); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    cycle();
  endtask

  task automatic test_zero();
    logic [N-1:0] v;
    int lat; bit ok; logic [5:0] c; logic yv;
    v = '0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %b expected 1", bus.in_ready); end
    run_vector(v, lat, ok, c, yv);
    checks++;
    if (!ok || lat != LATENCY) begin errors++; $display("FAIL zero_latency: got %0d (seen=%0b) expected %0d", lat, ok, LATENCY); end
    checks++;
    if (c !== 6'(ref_count(v))) begin errors++; $display("FAIL zero_count: got %0d expected %0d", c, ref_count(v)); end
    checks++;
    if (yv !== ref_y(v)) begin errors++; $display("FAIL zero_y: got %b expected %b", yv, ref_y(v)); end
  endtask

  task automatic test_all_ones();
    logic [N-1:0] v;
    int lat; bit ok; logic [5:0] c; logic yv;
    v = '1;
    run_vector(v, lat, ok, c, yv);
    checks++;
    if (!ok || lat != LATENCY) begin errors++; $display("FAIL ones_latency: got %0d (seen=%0b) expected %0d", lat, ok, LATENCY); end
    checks++;
    if (c !== 6'(ref_count(v))) begin errors++; $display("FAIL ones_count: got %0d expected %0d", c, ref_count(v)); end
    checks++;
    if (yv !== ref_y(v)) begin errors++; $display("FAIL ones_y: got %b expected %b", yv, ref_y(v)); end
  endtask

  task automatic test_threshold();
    logic [N-1:0] vecs [2];
    int lat; bit ok; logic [5:0] c; logic yv;
    vecs[0] = 63'h0000_0000_FFFF_FFFF;
    vecs[1] = 63'h0000_0000_7FFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      run_vector(vecs[k], lat, ok, c, yv);
      checks++;
      if (!ok || lat != LATENCY) begin errors++; $display("FAIL thresh_latency[%0d]: got %0d expected %0d", k, lat, LATENCY); end
      checks++;
      if (c !== 6'(ref_count(vecs[k]))) begin errors++; $display("FAIL thresh_count[%0d]: got %0d expected %0d", k, c, ref_count(vecs[k])); end
      checks++;
      if (yv !== ref_y(vecs[k])) begin errors++; $display("FAIL thresh_y[%0d]: got %b expected %b", k, yv, ref_y(vecs[k])); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] v1, v2;
    int lat; bit ok;
    v1 = rand_vec();
    v2 = ~v1 | 63'd1;
    bus.out_ready = 1'b0;
    bus.x         = v1;
    bus.in_valid  = 1'b1;
    cycle();
    // x changes and in_valid stays high through ACCUM: must not be sampled
    bus.x = v2;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(); lat++;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || lat != LATENCY) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, LATENCY); end
    $display("txn x=%h count=%0d y=%0b latency=%0d (held)", v1, bus.count, bus.y, lat);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.count !== 6'(ref_count(v1)) || bus.y !== ref_y(v1) || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b c=%0d y=%b rdy=%b expected v=1 c=%0d y=%b rdy=0",
                                  k, bus.out_valid, bus.count, bus.y, bus.in_ready, ref_count(v1), ref_y(v1)); end
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got out_valid=%b expected 0", bus.out_valid); end
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(); lat++;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || lat != LATENCY) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LATENCY); end
    checks++;
    if (bus.count !== 6'(ref_count(v2)) || bus.y !== ref_y(v2))
      begin errors++; $display("FAIL b2b_result: got c=%0d y=%b expected c=%0d y=%b", bus.count, bus.y, ref_count(v2), ref_y(v2)); end
    $display("txn x=%h count=%0d y=%0b latency=%0d (back-to-back)", v2, bus.count, bus.y, lat);
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] v3, v4;
    int lat; bit ok; int spurious;
    logic [5:0] c; logic yv;
    v3 = rand_vec() | 63'h7;
    v4 = rand_vec() & 63'h0F0F_0F0F_0F0F_0F0F;
    bus.out_ready = 1'b1;
    bus.x         = v3;
    bus.in_valid  = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 6'd0 || bus.y !== 1'b0)
      begin errors++; $display("FAIL midreset_clear: got v=%b c=%0d y=%b expected 0/0/0", bus.out_valid, bus.count, bus.y); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready: got %b expected 0", bus.in_ready); end
    cycle();
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.out_valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL midreset_stale: got %0d result cycles expected 0", spurious); end
    run_vector(v4, lat, ok, c, yv);
    checks++;
    if (!ok || lat != LATENCY) begin errors++; $display("FAIL postreset_latency: got %0d expected %0d", lat, LATENCY); end
    checks++;
    if (c !== 6'(ref_count(v4)) || yv !== ref_y(v4))
      begin errors++; $display("FAIL postreset_result: got c=%0d y=%b expected c=%0d y=%b", c, yv, ref_count(v4), ref_y(v4)); end
  endtask

  task automatic test_random();
    int           exp_q[$];
    int           accepted, retired, cyc, expc;
    logic [N-1:0] v;
    bit           hold_valid;
    logic [5:0]   hold_c;
    logic         hold_y;
    accepted = 0; retired = 0; cyc = 0; hold_valid = 1'b0;
    hold_c = '0; hold_y = 1'b0;
    while ((accepted < NUM_RAND || exp_q.size() > 0) && cyc < 60000) begin
      if (hold_valid) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.count !== hold_c || bus.y !== hold_y)
          begin errors++; $display("FAIL rand_stable: got v=%b c=%0d y=%b expected v=1 c=%0d y=%b",
                                    bus.out_valid, bus.count, bus.y, hold_c, hold_y); end
      end
      v             = rand_vec();
      bus.x         = v;
      bus.in_valid  = (accepted < NUM_RAND) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_count(v));
        accepted++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: got result c=%0d with nothing outstanding", bus.count);
        end else begin
          expc = exp_q.pop_front();
          if (bus.count !== 6'(expc) || bus.y !== (expc >= THR))
            begin errors++; $display("FAIL rand_result[%0d]: got c=%0d y=%b expected c=%0d y=%b",
                                      retired, bus.count, bus.y, expc, (expc >= THR)); end
          $display("txn %0d count=%0d y=%0b", retired, bus.count, bus.y);
          retired++;
        end
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_c     = bus.count;
      hold_y     = bus.y;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (accepted != NUM_RAND || exp_q.size() != 0)
      begin errors++; $display("FAIL rand_timeout: got accepted=%0d outstanding=%0d expected %0d/0", accepted, exp_q.size(), NUM_RAND); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_all_ones();
    test_threshold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
